// File: rtl/ipm_distributed_fifo_fwft_rd_pkg.sv
// Shared FSM encoding and read-latency helpers for the FWFT read adapter.
package ipm_distributed_fifo_fwft_rd_pkg;

   typedef enum logic [0:0] {
      StRun   = 1'b0,
      StDrain = 1'b1
   } fwft_state_e;

   function automatic int unsigned rd_lat(input int unsigned out_reg);
      return 1 + out_reg;
   endfunction

   // One slot per in-flight read plus one, so a full pipe never stalls the stream.
   function automatic int unsigned buf_depth(input int unsigned out_reg);
      return rd_lat(out_reg) + 1;
   endfunction

endpackage

// File: rtl/ipm_fwft_rd_lat_pipe.sv
// Valid shift register marking the cycle in which each issued FIFO read returns data.
module ipm_fwft_rd_lat_pipe #(
   parameter int unsigned RD_LAT = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic issue_i,
   output logic capture_o
);

   logic [RD_LAT-1:0] sr_q, sr_d;

   always_comb begin
      sr_d    = sr_q << 1;
      sr_d[0] = issue_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clr_i) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign capture_o = sr_q[RD_LAT-1];

endmodule

// File: rtl/ipm_distributed_fifo_fwft_rd.sv
// First-word-fall-through adapter in front of a fixed-latency FIFO read port.
// Define IPM_FWFT_RD_LEVEL_EN to expose the buffer occupancy on buf_level.
module ipm_distributed_fifo_fwft_rd
   import ipm_distributed_fifo_fwft_rd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OUT_REG    = 0
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   input  logic                  flush,
   output logic                  m_valid,
   input  logic                  m_ready,
`ifdef IPM_FWFT_RD_LEVEL_EN
   output logic [$clog2(buf_depth(OUT_REG)+1)-1:0] buf_level,
`endif
   output logic [DATA_WIDTH-1:0] m_data
);

   localparam int unsigned RdLat    = rd_lat(OUT_REG);
   localparam int unsigned BufDepth = buf_depth(OUT_REG);
   localparam int unsigned CntW     = $clog2(BufDepth + 1);
   localparam int unsigned PtrW     = $clog2(BufDepth);
   localparam int unsigned InfW     = $clog2(RdLat + 1);
   localparam int unsigned SumW     = CntW + 1;
   localparam logic [PtrW-1:0] PtrLast = PtrW'(BufDepth - 1);

   fwft_state_e           state_q, state_d;
   logic [DATA_WIDTH-1:0] mem_q [BufDepth];
   logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [InfW-1:0]       inflight_q, inflight_d;
   logic                  capture, wr, pop;
   logic [SumW-1:0]       occupancy;

   // Flush clears the pipe so returns of reads issued before it are never captured.
   ipm_fwft_rd_lat_pipe #(
      .RD_LAT (RdLat)
   ) u_lat_pipe (
      .clk_i     (rd_clk),
      .rst_ni    (rd_rst_n),
      .clr_i     (flush),
      .issue_i   (fifo_rd_en),
      .capture_o (capture)
   );

   assign m_valid = rd_rst_n & (state_q == StRun) & (count_q != '0);
   assign m_data  = rd_rst_n ? mem_q[head_q] : '0;

   always_comb begin
      pop        = m_valid & m_ready;
      wr         = capture & (state_q == StRun) & ~flush;
      occupancy  = SumW'(count_q) + SumW'(inflight_q) - SumW'(pop);
      fifo_rd_en = rd_rst_n & (state_q == StRun) & ~flush & ~fifo_empty &
                   (occupancy < SumW'(BufDepth));

      state_d    = state_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      inflight_d = inflight_q;

      unique case (state_q)
         StRun:   if (flush) state_d = StDrain;
         StDrain: if (!flush && inflight_q == '0) state_d = StRun;
      endcase

      if (flush) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         inflight_d = '0;
      end else begin
         if (wr) tail_d = (tail_q == PtrLast) ? '0 : tail_q + 1'b1;
         if (pop) head_d = (head_q == PtrLast) ? '0 : head_q + 1'b1;
         count_d    = count_q + CntW'(wr) - CntW'(pop);
         inflight_d = inflight_q + InfW'(fifo_rd_en) - InfW'(capture);
      end
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         state_q    <= StRun;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         for (int i = 0; i < int'(BufDepth); i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         if (wr) mem_q[tail_q] <= fifo_rd_data;
      end
   end

`ifdef IPM_FWFT_RD_LEVEL_EN
   assign buf_level = (rd_rst_n && state_q == StRun) ? count_q : '0;
`else
   // Occupancy stays internal in this build.
`endif

endmodule

// File: tb/tb_ipm_distributed_fifo_fwft_rd.sv
// Bench for the FWFT read adapter: one instance per OUT_REG setting, each fed by a FIFO model.
module tb_ipm_distributed_fifo_fwft_rd;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n      [2];
   logic       flush      [2];
   logic       m_ready    [2];
   logic       fifo_empty [2];
   logic       rd_en      [2];
   logic       m_valid    [2];
   logic [7:0] rd_data    [2];
   logic [7:0] m_data     [2];
`ifdef IPM_FWFT_RD_LEVEL_EN
   logic [1:0] lvl0, lvl1;
`endif

   ipm_distributed_fifo_fwft_rd #(.DATA_WIDTH(8), .OUT_REG(0)) dut0 (
      .rd_clk       (clk),
      .rd_rst_n     (rst_n[0]),
      .fifo_rd_en   (rd_en[0]),
      .fifo_rd_data (rd_data[0]),
      .fifo_empty   (fifo_empty[0]),
      .flush        (flush[0]),
      .m_valid      (m_valid[0]),
      .m_ready      (m_ready[0]),
`ifdef IPM_FWFT_RD_LEVEL_EN
      .buf_level    (lvl0),
`endif
      .m_data       (m_data[0])
   );

   ipm_distributed_fifo_fwft_rd #(.DATA_WIDTH(8), .OUT_REG(1)) dut1 (
      .rd_clk       (clk),
      .rd_rst_n     (rst_n[1]),
      .fifo_rd_en   (rd_en[1]),
      .fifo_rd_data (rd_data[1]),
      .fifo_empty   (fifo_empty[1]),
      .flush        (flush[1]),
      .m_valid      (m_valid[1]),
      .m_ready      (m_ready[1]),
`ifdef IPM_FWFT_RD_LEVEL_EN
      .buf_level    (lvl1),
`endif
      .m_data       (m_data[1])
   );

   // FIFO model: read data appears 1 (dut0) or 2 (dut1) cycles after an accepted read.
   logic [7:0] fmem [2][256];
   logic [7:0] wp [2] = '{8'd0, 8'd0};
   logic [7:0] rp [2] = '{8'd0, 8'd0};
   logic [7:0] stage1 [2];
   logic [7:0] stage2;

   assign fifo_empty[0] = (wp[0] == rp[0]);
   assign fifo_empty[1] = (wp[1] == rp[1]);
   assign rd_data[0]    = stage1[0];
   assign rd_data[1]    = stage2;

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (rd_en[g] && !fifo_empty[g]) begin
            stage1[g] <= fmem[g][rp[g]];
            rp[g]     <= rp[g] + 8'd1;
         end
      end
      stage2 <= stage1[1];
   end

   // Scoreboard: words pushed into the FIFO are the expected stream, in order.
   logic [7:0] exp0 [$];
   logic [7:0] exp1 [$];
   int delivered [2] = '{0, 0};
   int n_checks = 0;
   int n_fail   = 0;

   function automatic int exp_size(input int g);
      return (g == 0) ? exp0.size() : exp1.size();
   endfunction

   function automatic logic [7:0] exp_front(input int g);
      return (g == 0) ? exp0[0] : exp1[0];
   endfunction

   function automatic void exp_pop(input int g);
      if (g == 0) void'(exp0.pop_front());
      else        void'(exp1.pop_front());
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int g, input logic [7:0] w);
      fmem[g][wp[g]] = w;
      wp[g] = wp[g] + 8'd1;
      if (g == 0) exp0.push_back(w);
      else        exp1.push_back(w);
   endtask

   // Compares every valid word against the head of the expected stream; on flush or reset
   // the words already read from the FIFO but not delivered are dropped from the model.
   task automatic scoreboard();
      logic [7:0] occ;
      for (int g = 0; g < 2; g++) begin
         if (m_valid[g]) begin
            if (exp_size(g) == 0) begin
               check($sformatf("dut%0d valid with no word expected", g), int'(m_valid[g]), 0);
            end else begin
               check($sformatf("dut%0d m_data", g), int'(m_data[g]), int'(exp_front(g)));
               if (m_ready[g]) begin
                  exp_pop(g);
                  delivered[g]++;
               end
            end
         end
         if (flush[g] || !rst_n[g]) begin
            occ = wp[g] - rp[g];
            while (exp_size(g) > int'(occ)) exp_pop(g);
         end
      end
   endtask

   task automatic sample();
      @(negedge clk);
      scoreboard();
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int g);
      int k = 0;
      while ((exp_size(g) != 0 || !fifo_empty[g]) && k < 300) begin
         sample();
         advance();
         k++;
      end
      for (int i = 0; i < 3; i++) begin
         sample();
         advance();
      end
      check($sformatf("dut%0d stream drained", g), exp_size(g), 0);
   endtask

   typedef struct {
      int         dut;
      int         nwords;
      logic [7:0] base;
      logic [7:0] ready_pat;
      int         exp_first;
      int         exp_span;
   } vec_t;

   vec_t vecs [5];

   task automatic run_vec(input vec_t v);
      int g      = v.dut;
      int first  = -1;
      int last   = -1;
      int target = delivered[v.dut] + v.nwords;
      for (int i = 0; i < v.nwords; i++) push(g, v.base + 8'(i));
      for (int k = 0; k < 200; k++) begin
         m_ready[g] = v.ready_pat[k % 8];
         sample();
         if (m_valid[g] && first < 0) first = k;
         if (delivered[g] == target) begin
            last = k;
            break;
         end
         advance();
      end
      advance();
      check($sformatf("dut%0d first m_valid latency", g), first, v.exp_first);
      check($sformatf("dut%0d all %0d words delivered", g, v.nwords), delivered[g], target);
      if (v.exp_span >= 0) check($sformatf("dut%0d back-to-back span", g), last - first, v.exp_span);
      drain(g);
   endtask

   initial begin
      int rd_cnt;
      int start;

      vecs[0] = '{dut: 0, nwords: 3,  base: 8'hA1, ready_pat: 8'hFF, exp_first: 2, exp_span: 2};
      vecs[1] = '{dut: 1, nwords: 5,  base: 8'h10, ready_pat: 8'hFF, exp_first: 3, exp_span: 4};
      vecs[2] = '{dut: 0, nwords: 16, base: 8'h20, ready_pat: 8'h55, exp_first: 2, exp_span: -1};
      vecs[3] = '{dut: 1, nwords: 16, base: 8'h40, ready_pat: 8'h33, exp_first: 3, exp_span: -1};
      vecs[4] = '{dut: 0, nwords: 1,  base: 8'h77, ready_pat: 8'hFF, exp_first: 2, exp_span: 0};

      for (int g = 0; g < 2; g++) begin
         rst_n[g]   = 1'b0;
         flush[g]   = 1'b0;
         m_ready[g] = 1'b0;
      end
      advance();
      sample();
      for (int g = 0; g < 2; g++) begin
         check($sformatf("dut%0d reset m_valid", g), int'(m_valid[g]), 0);
         check($sformatf("dut%0d reset fifo_rd_en", g), int'(rd_en[g]), 0);
         check($sformatf("dut%0d reset m_data", g), int'(m_data[g]), 0);
      end
      advance();
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      sample();
      for (int g = 0; g < 2; g++) begin
         check($sformatf("dut%0d idle m_valid", g), int'(m_valid[g]), 0);
         check($sformatf("dut%0d idle m_data", g), int'(m_data[g]), 0);
      end
      advance();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Stall with m_ready low: reads stop once the buffer and pipe are full.
      m_ready[1] = 1'b0;
      for (int i = 0; i < 8; i++) push(1, 8'hB0 + 8'(i));
      rd_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         sample();
         if (rd_en[1]) rd_cnt++;
`ifdef IPM_FWFT_RD_LEVEL_EN
         check("buf_level while stalled", int'(lvl1), (k < 3) ? 0 : ((k - 2 > 3) ? 3 : k - 2));
`endif
         advance();
      end
      check("reads issued while stalled", rd_cnt, 3);
      m_ready[1] = 1'b1;
      start = delivered[1];
      for (int k = 0; k < 8; k++) begin
         sample();
         check($sformatf("stall release word %0d delivered", k), delivered[1] - start, k + 1);
         advance();
      end
      drain(1);

      // Flush with two words buffered and one read still in flight.
      m_ready[1] = 1'b0;
      start = delivered[1];
      for (int i = 0; i < 6; i++) push(1, 8'hC0 + 8'(i));
      for (int k = 0; k < 4; k++) begin
         sample();
         advance();
      end
      flush[1] = 1'b1;
      sample();
      check("m_valid before flush edge", int'(m_valid[1]), 1);
      advance();
      flush[1] = 1'b0;
      sample();
      check("m_valid after flush", int'(m_valid[1]), 0);
      check("fifo_rd_en while draining", int'(rd_en[1]), 0);
      advance();
      sample();
      check("fifo_rd_en resumes after drain", int'(rd_en[1]), 1);
      advance();
      m_ready[1] = 1'b1;
      drain(1);
      check("words surviving flush", delivered[1] - start, 3);

      // One-cycle reset mid-stream; the read issued just before it returns after release.
      m_ready[1] = 1'b1;
      start = delivered[1];
      for (int i = 0; i < 10; i++) push(1, 8'hD0 + 8'(i));
      for (int k = 0; k < 4; k++) begin
         sample();
         advance();
      end
      rst_n[1] = 1'b0;
      sample();
      check("mid-stream reset m_valid", int'(m_valid[1]), 0);
      check("mid-stream reset fifo_rd_en", int'(rd_en[1]), 0);
      check("mid-stream reset m_data", int'(m_data[1]), 0);
      advance();
      rst_n[1] = 1'b1;
      sample();
      check("after reset m_valid", int'(m_valid[1]), 0);
      check("after reset m_data", int'(m_data[1]), 0);
      advance();
      drain(1);
      check("words surviving reset", delivered[1] - start, 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ipm_distributed_fifo_fwft_rd.md
IPM_DISTRIBUTED_FIFO_FWFT_RD -- requirements
Module: ipm_distributed_fifo_fwft_rd

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO read data and stream data (1..256).
REQ-002 Parameter OUT_REG, default 0, FIFO output register setting (0 or 1); FIFO read latency RD_LAT = 1 + OUT_REG cycles.
REQ-003 Port rd_clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rd_rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port fifo_rd_en  output  1  read enable to FIFO read side.
REQ-006 Port fifo_rd_data  input  DATA_WIDTH  FIFO read data; valid exactly RD_LAT cycles after an accepted fifo_rd_en.
REQ-007 Port fifo_empty  input  1  FIFO empty flag.
REQ-008 Port flush  input  1  discard buffered and in-flight words.
REQ-009 Port m_valid  output  1  stream word available.
REQ-010 Port m_ready  input  1  consumer accepts word.
REQ-011 Port m_data  output  DATA_WIDTH  stream word (first-word-fall-through).

Function
REQ-012 Internal buffer SHALL hold BUF_DEPTH = RD_LAT + 1 words in circular order, with a head pointer, a tail pointer and a count of 0..BUF_DEPTH.
REQ-013 In-flight counter (0..RD_LAT) SHALL increment on fifo_rd_en, decrement when returned data is captured; a RD_LAT-deep valid shift register SHALL mark capture cycles.
REQ-014 fifo_rd_en SHALL equal (state==RUN) & ~flush & ~fifo_empty & (count + inflight - pop < BUF_DEPTH), where pop = m_valid & m_ready.
REQ-015 Returned word SHALL be written at the tail in its capture cycle; capture and pop in the same cycle SHALL leave count unchanged.
REQ-016 m_valid SHALL be 1 iff count > 0 and state==RUN; m_data SHALL be the head entry, combinationally.
REQ-017 m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-018 With m_ready held 1 and FIFO non-empty, throughput SHALL be one word per cycle; first m_valid SHALL rise RD_LAT+1 cycles after fifo_empty falls with the block idle.
REQ-019 Word order SHALL equal FIFO order; no word dropped or duplicated except by flush.
REQ-020 FSM states RUN and DRAIN; RUN->DRAIN on flush=1; DRAIN->RUN on the cycle inflight reaches 0 with flush=0; reset state RUN.
REQ-021 On flush: count, head, tail cleared next cycle; m_valid=0 and fifo_rd_en=0 throughout DRAIN; words returning during DRAIN discarded.
REQ-022 Pointers SHALL wrap from BUF_DEPTH-1 to 0; count SHALL never exceed BUF_DEPTH.

Reset
REQ-023 While rd_rst_n=0 at a clock edge: state RUN, count 0, inflight 0, pointers 0, valid shift register 0, buffer entries 0.
REQ-024 Reset values: m_valid=0, m_data=0, fifo_rd_en=0 (forced 0 while rd_rst_n=0).
REQ-025 Reset mid-stream SHALL discard in-flight returns arriving after reset release.

Configuration
REQ-026 Macro IPM_FWFT_RD_LEVEL_EN defined: extra output port buf_level (width clog2(BUF_DEPTH+1)) equal to count, 0 at reset and during DRAIN.
REQ-027 Macro undefined: port buf_level absent; all other behaviour identical.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding (RUN, DRAIN) and the constant functions RD_LAT and BUF_DEPTH from OUT_REG.
REQ-029 One sub-module, ipm_fwft_rd_lat_pipe, SHALL implement the RD_LAT-deep valid shift register with flush/reset clear.

Verification
REQ-030 OUT_REG=0, FIFO holds 0xA1,0xA2,0xA3, m_ready=1 -> m_data 0xA1,0xA2,0xA3 on three consecutive cycles, first m_valid 2 cycles after first fifo_rd_en cycle... i.e. RD_LAT+1=2 after fifo_empty falls.
REQ-031 OUT_REG=1, 8 words, m_ready=0 for 10 cycles then 1 -> fifo_rd_en stops after 3 reads, buffer count 3, then 8 words delivered in order, one per cycle.
REQ-032 m_ready toggling 1,0,1,0 over 16 words -> every word delivered exactly once, m_data stable on each stall cycle.
REQ-033 flush asserted with count=2, inflight=1 -> m_valid 0 next cycle, the in-flight word dropped, fifo_rd_en 0 until inflight=0, then streaming resumes with the next FIFO word.
REQ-034 rd_rst_n=0 for 1 cycle mid-stream -> m_valid=0, fifo_rd_en=0, m_data=0 after the edge; data returning later is ignored.
REQ-035 IPM_FWFT_RD_LEVEL_EN defined, m_ready=0 with FIFO non-empty -> buf_level counts 1,2 up to BUF_DEPTH and saturates.
